sao_bo_stat_ctrl: RTL and testbench

Sequencer and accumulator for SAO band-offset statistics over one CTB. It accepts 4-pixel groups of clipped differences and band categories from the SAO statistics front end under a valid/ready handshake. It counts groups against the programmed CTB size and accumulates per-band sums and counts for all 32 bands. It then streams the 32 band results to the offset-decision stage under a second valid/ready handshake.

---
 rtl/sao_bo_pkg.sv | 20 ++
 rtl/sao_bo_stat_ctrl_if.sv | 27 ++
 rtl/sao_bo_band_acc.sv | 24 ++
 rtl/sao_bo_stat_ctrl.sv | 146 ++++++++++++++
 tb/tb_sao_bo_stat_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sao_bo_pkg.sv
// SAO band-offset statistics: shared widths, types and controller state encoding.
package sao_bo_pkg;
  localparam int DIFF_CLIP_BIT = 4;
  localparam int N_PIX         = 4;
  localparam int N_BO_TYPE     = 5;
  localparam int N_BAND        = 1 << N_BO_TYPE;
  localparam int ACC_BIT       = 17;
  localparam int CNT_BIT       = 13;
  // Largest CTB is 16 groups x 64 rows = 1024 groups.
  localparam int GRP_BIT       = 11;

  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_DRAIN, ST_READ} bo_ctrl_state_e;

  typedef logic signed [DIFF_CLIP_BIT:0] diff_t;
  typedef logic [N_BO_TYPE-1:0]          band_t;
  typedef logic signed [ACC_BIT-1:0]     acc_t;
  typedef logic [CNT_BIT-1:0]            cnt_t;
  typedef logic [2:0]                    pix_cnt_t;
  typedef logic [GRP_BIT-1:0]            grp_t;
endpackage

// File: rtl/sao_bo_stat_ctrl_if.sv
// Group input stream (front end -> block) and band result stream (block -> offset decision).
interface sao_bo_stat_ctrl_if;
  import sao_bo_pkg::*;

  logic             in_valid;
  logic             in_ready;
  diff_t            in_diff [N_PIX];
  band_t            in_cate [N_PIX];
  logic [N_PIX-1:0] in_use;

  logic             out_valid;
  logic             out_ready;
  band_t            out_band;
  acc_t             out_sum;
  cnt_t             out_cnt;
  logic             out_last;

  modport slave (
    input  in_valid, in_diff, in_cate, in_use, out_ready,
    output in_ready, out_valid, out_band, out_sum, out_cnt, out_last
  );

  modport master (
    output in_valid, in_diff, in_cate, in_use, out_ready,
    input  in_ready, out_valid, out_band, out_sum, out_cnt, out_last
  );
endinterface

// File: rtl/sao_bo_band_acc.sv
// Combinational fan-out of one 4-pixel group into per-band (sum, count) deltas.
// A masked pixel contributes nothing; several pixels may land in the same band.
module sao_bo_band_acc
  import sao_bo_pkg::*;
(
  input  diff_t            diff_i    [N_PIX],
  input  band_t            cate_i    [N_PIX],
  input  logic [N_PIX-1:0] use_i,
  output acc_t             sum_dlt_o [N_BAND],
  output pix_cnt_t         cnt_dlt_o [N_BAND]
);
  always_comb begin
    for (int b = 0; b < N_BAND; b++) begin
      sum_dlt_o[b] = '0;
      cnt_dlt_o[b] = '0;
      for (int i = 0; i < N_PIX; i++) begin
        if (use_i[i] && cate_i[i] == band_t'(b)) begin
          sum_dlt_o[b] = sum_dlt_o[b] + acc_t'(diff_i[i]);
          cnt_dlt_o[b] = cnt_dlt_o[b] + pix_cnt_t'(1);
        end
      end
    end
  end
endmodule

// File: rtl/sao_bo_stat_ctrl.sv
// SAO band-offset statistics sequencer: accepts CTB groups, accumulates 32 band sums/counts,
// then streams the 32 results out; group latency 2 cycles to accumulators, first result 2 cycles after last accept.
module sao_bo_stat_ctrl
  import sao_bo_pkg::*;
(
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [4:0]               ctb_wg,
  input  logic [6:0]               ctb_h,
  sao_bo_stat_ctrl_if.slave        bus,
  output logic                     busy,
  output logic                     done
);
  bo_ctrl_state_e   state_q;
  grp_t             total_q, grp_cnt_q;
  band_t            rd_idx_q;
  logic             done_q;

  logic             s1_vld_q;
  diff_t            s1_diff_q [N_PIX];
  band_t            s1_cate_q [N_PIX];
  logic [N_PIX-1:0] s1_use_q;

  acc_t             sum_q [N_BAND];
  cnt_t             cnt_q [N_BAND];
  acc_t             sum_d [N_BAND];
  cnt_t             cnt_d [N_BAND];
  acc_t             sum_dlt [N_BAND];
  pix_cnt_t         cnt_dlt [N_BAND];

  logic             in_hs, out_hs, out_vld;

  sao_bo_band_acc u_band_acc (
    .diff_i    (s1_diff_q),
    .cate_i    (s1_cate_q),
    .use_i     (s1_use_q),
    .sum_dlt_o (sum_dlt),
    .cnt_dlt_o (cnt_dlt)
  );

  always_comb begin
    for (int b = 0; b < N_BAND; b++) begin
      sum_d[b] = sum_q[b] + sum_dlt[b];
      cnt_d[b] = cnt_q[b] + cnt_t'(cnt_dlt[b]);
    end
  end

  assign out_vld = (state_q == ST_READ);
  assign in_hs   = bus.in_valid && (state_q == ST_ACC);
  assign out_hs  = out_vld && bus.out_ready;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= ST_IDLE;
      total_q   <= '0;
      grp_cnt_q <= '0;
      rd_idx_q  <= '0;
      done_q    <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_use_q  <= '0;
      for (int i = 0; i < N_PIX; i++) begin
        s1_diff_q[i] <= '0;
        s1_cate_q[i] <= '0;
      end
      for (int b = 0; b < N_BAND; b++) begin
        sum_q[b] <= '0;
        cnt_q[b] <= '0;
      end
    end else if (!rst_n) begin
      state_q   <= ST_IDLE;
      total_q   <= '0;
      grp_cnt_q <= '0;
      rd_idx_q  <= '0;
      done_q    <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_use_q  <= '0;
      for (int i = 0; i < N_PIX; i++) begin
        s1_diff_q[i] <= '0;
        s1_cate_q[i] <= '0;
      end
      for (int b = 0; b < N_BAND; b++) begin
        sum_q[b] <= '0;
        cnt_q[b] <= '0;
      end
    end else begin
      done_q   <= 1'b0;
      s1_vld_q <= in_hs;
      if (in_hs) begin
        s1_diff_q <= bus.in_diff;
        s1_cate_q <= bus.in_cate;
        s1_use_q  <= bus.in_use;
      end
      if (s1_vld_q) begin
        for (int b = 0; b < N_BAND; b++) begin
          sum_q[b] <= sum_d[b];
          cnt_q[b] <= cnt_d[b];
        end
      end
      // The start clear is placed after the commit so it wins on the same edge.
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_ACC;
            total_q   <= grp_t'(ctb_wg) * grp_t'(ctb_h);
            grp_cnt_q <= '0;
            for (int b = 0; b < N_BAND; b++) begin
              sum_q[b] <= '0;
              cnt_q[b] <= '0;
            end
          end
        end
        ST_ACC: begin
          if (in_hs) begin
            grp_cnt_q <= grp_cnt_q + grp_t'(1);
            if (grp_cnt_q == total_q - grp_t'(1)) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          state_q  <= ST_READ;
          rd_idx_q <= '0;
        end
        ST_READ: begin
          if (out_hs) begin
            rd_idx_q <= rd_idx_q + band_t'(1);
            if (rd_idx_q == band_t'(N_BAND - 1)) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_ACC);
  assign bus.out_valid = out_vld;
  assign bus.out_band  = out_vld ? rd_idx_q : '0;
  assign bus.out_sum   = out_vld ? sum_q[rd_idx_q] : '0;
  assign bus.out_cnt   = out_vld ? cnt_q[rd_idx_q] : '0;
  assign bus.out_last  = out_vld && (rd_idx_q == band_t'(N_BAND - 1));
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
endmodule

// File: tb/tb_sao_bo_stat_ctrl.sv
// Self-checking bench for sao_bo_stat_ctrl: table-driven 1x1 CTBs, random CTBs vs. a band histogram model,
// full 64x64 CTB, output backpressure, reset mid-accumulation and start while busy.
module tb_sao_bo_stat_ctrl;
  import sao_bo_pkg::*;

  logic       clk = 1'b0;
  logic       arst_n, rst_n, start;
  logic [4:0] ctb_wg;
  logic [6:0] ctb_h;
  logic       busy, done;

  sao_bo_stat_ctrl_if ifc ();

  sao_bo_stat_ctrl dut (
    .clk    (clk),
    .arst_n (arst_n),
    .rst_n  (rst_n),
    .start  (start),
    .ctb_wg (ctb_wg),
    .ctb_h  (ctb_h),
    .bus    (ifc.slave),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][4:0] d;
    logic [3:0][4:0] c;
    logic [3:0]      u;
  } grp_s;

  typedef struct {
    grp_s g;
    int   b0, s0, c0;
    int   b1, s1, c1;
  } vec_s;

  int   checks = 0;
  int   failures = 0;
  int   accepts;
  grp_s q[$];
  int   exp_sum[32], exp_cnt[32], got_sum[32], got_cnt[32];
  vec_s tbl[6];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic grp_s mk(input int d0, d1, d2, d3, c0, c1, c2, c3, input logic [3:0] u);
    grp_s g;
    g.d[0] = 5'(d0); g.d[1] = 5'(d1); g.d[2] = 5'(d2); g.d[3] = 5'(d3);
    g.c[0] = 5'(c0); g.c[1] = 5'(c1); g.c[2] = 5'(c2); g.c[3] = 5'(c3);
    g.u = u;
    return g;
  endfunction

  function automatic grp_s rnd_grp();
    grp_s g;
    for (int i = 0; i < 4; i++) begin
      g.d[i] = 5'($urandom_range(31));
      g.c[i] = ($urandom_range(1) == 1) ? 5'($urandom_range(3)) : 5'($urandom_range(31));
    end
    g.u = 4'($urandom_range(15));
    return g;
  endfunction

  // Reference: band histogram of every used pixel in the CTB.
  task automatic model_q();
    for (int b = 0; b < 32; b++) begin
      exp_sum[b] = 0;
      exp_cnt[b] = 0;
    end
    foreach (q[k])
      for (int i = 0; i < 4; i++)
        if (q[k].u[i]) begin
          exp_sum[q[k].c[i]] += $signed(q[k].d[i]);
          exp_cnt[q[k].c[i]] += 1;
        end
  endtask

  task automatic cmp_results(input string tag);
    for (int b = 0; b < 32; b++) begin
      chk($sformatf("%s_sum_b%0d", tag, b), got_sum[b], exp_sum[b]);
      chk($sformatf("%s_cnt_b%0d", tag, b), got_cnt[b], exp_cnt[b]);
    end
  endtask

  task automatic start_ctb(input int wg, input int h);
    ctb_wg = 5'(wg);
    ctb_h  = 7'(h);
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("in_ready_after_start", ifc.in_ready, 1);
    chk("done_one_cycle", done, 0);
  endtask

  task automatic send_group(input grp_s g, input int gap_pct);
    int cyc;
    while ($urandom_range(99) < gap_pct) begin
      ifc.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
        ifc.in_diff[i] = diff_t'($urandom_range(31));
        ifc.in_cate[i] = band_t'($urandom_range(31));
      end
      ifc.in_use = 4'($urandom_range(15));
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) begin
      ifc.in_diff[i] = diff_t'(g.d[i]);
      ifc.in_cate[i] = band_t'(g.c[i]);
    end
    ifc.in_use   = g.u;
    ifc.in_valid = 1'b1;
    cyc = 0;
    while (!ifc.in_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!ifc.in_ready) begin
      ifc.in_valid = 1'b0;
      chk("in_ready_timeout", 0, 1);
    end else begin
      @(posedge clk); #1;
      ifc.in_valid = 1'b0;
      accepts++;
    end
  endtask

  // Called right after the last accept edge: one DRAIN cycle, then results.
  task automatic check_drain();
    chk("in_ready_after_last", ifc.in_ready, 0);
    chk("out_valid_in_drain", ifc.out_valid, 0);
    chk("busy_in_drain", busy, 1);
    @(posedge clk); #1;
    chk("first_result_latency", ifc.out_valid, 1);
  endtask

  task automatic read_results(input int rdy_pct, input bit poke_start);
    int cyc = 0, nxt = 0, pb = 0, ps = 0, pc = 0;
    bit stalled = 1'b0, fin = 1'b0;
    while (!fin && cyc < 2000) begin
      ifc.out_ready = ($urandom_range(99) < rdy_pct);
      ifc.in_valid  = 1'($urandom_range(1));
      start  = poke_start && (nxt == 10);
      ctb_wg = 5'd1;
      ctb_h  = 7'd1;
      chk("out_valid_in_read", ifc.out_valid, 1);
      chk("in_ready_in_read", ifc.in_ready, 0);
      chk("done_only_at_end", done, 0);
      if (ifc.out_valid) begin
        if (stalled) begin
          chk("stall_band_stable", ifc.out_band, pb);
          chk("stall_sum_stable", ifc.out_sum, ps);
          chk("stall_cnt_stable", ifc.out_cnt, pc);
        end
        chk("band_order", ifc.out_band, nxt);
        chk("out_last", ifc.out_last, nxt == 31);
        pb = ifc.out_band;
        ps = ifc.out_sum;
        pc = ifc.out_cnt;
        stalled = !ifc.out_ready;
        if (ifc.out_ready) begin
          got_sum[nxt] = ifc.out_sum;
          got_cnt[nxt] = ifc.out_cnt;
          nxt++;
          if (nxt == 32) fin = 1'b1;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    start         = 1'b0;
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b0;
    if (!fin) chk("read_timeout_bands", nxt, 32);
    chk("done_pulse", done, 1);
    chk("busy_after_done", busy, 0);
    chk("out_valid_after_done", ifc.out_valid, 0);
    chk("out_last_after_done", ifc.out_last, 0);
  endtask

  task automatic run_vec(input vec_s v, input string tag);
    q = {v.g};
    start_ctb(1, 1);
    send_group(v.g, 0);
    check_drain();
    read_results(70, 1'b0);
    for (int b = 0; b < 32; b++) begin
      exp_sum[b] = 0;
      exp_cnt[b] = 0;
    end
    exp_sum[v.b0] = v.s0; exp_cnt[v.b0] = v.c0;
    exp_sum[v.b1] = v.s1; exp_cnt[v.b1] = v.c1;
    cmp_results(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{mk(3, -2, 5, 1, 7, 7, 7, 20, 4'b1111),       7,   6, 3, 20,  1, 1};
    tbl[1] = '{mk(3, -2, 5, 1, 7, 7, 7, 20, 4'b0101),       7,   8, 2, 20,  0, 0};
    tbl[2] = '{mk(-16, -16, -16, -16, 0, 0, 0, 0, 4'b1111), 0, -64, 4, 31,  0, 0};
    tbl[3] = '{mk(15, 15, 15, 15, 31, 0, 31, 0, 4'b1111),  31,  30, 2,  0, 30, 2};
    tbl[4] = '{mk(-7, 9, 4, -1, 12, 12, 3, 12, 4'b1000),   12,  -1, 1,  3,  0, 0};
    tbl[5] = '{mk(5, 5, 5, 5, 1, 2, 3, 4, 4'b0000),         1,   0, 0,  2,  0, 0};

    arst_n = 1'b0; rst_n = 1'b1; start = 1'b0;
    ctb_wg = '0; ctb_h = '0;
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b0; ifc.in_use = '0;
    for (int i = 0; i < 4; i++) begin
      ifc.in_diff[i] = '0;
      ifc.in_cate[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", ifc.in_ready, 0);
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_out_last", ifc.out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_band", ifc.out_band, 0);
    chk("rst_out_sum", ifc.out_sum, 0);
    chk("rst_out_cnt", ifc.out_cnt, 0);
    arst_n = 1'b1;
    @(posedge clk); #1;

    // Table of single-group CTBs; each starts the cycle after the previous done.
    for (int k = 0; k < 6; k++) run_vec(tbl[k], $sformatf("tbl%0d", k));

    // Random small CTBs against the histogram model.
    for (int it = 0; it < 4; it++) begin
      int wg = $urandom_range(4, 1);
      int h  = $urandom_range(3, 1);
      q.delete();
      for (int k = 0; k < wg * h; k++) q.push_back(rnd_grp());
      model_q();
      accepts = 0;
      start_ctb(wg, h);
      foreach (q[k]) send_group(q[k], 25);
      chk("rand_accepts", accepts, wg * h);
      check_drain();
      read_results(60, 1'b0);
      cmp_results($sformatf("rand%0d", it));
    end

    // Full 64x64 CTB with input gaps and output backpressure.
    q.delete();
    for (int k = 0; k < 1024; k++) q.push_back(mk(-16, -16, -16, -16, 31, 31, 31, 31, 4'b1111));
    model_q();
    accepts = 0;
    start_ctb(16, 64);
    foreach (q[k]) send_group(q[k], 30);
    chk("full_accepts", accepts, 1024);
    check_drain();
    read_results(50, 1'b0);
    chk("full_b31_sum", got_sum[31], -65536);
    chk("full_b31_cnt", got_cnt[31], 4096);
    cmp_results("full");

    // Synchronous clear in the middle of accumulation.
    start_ctb(16, 16);
    for (int k = 0; k < 100; k++) send_group(rnd_grp(), 10);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("srst_busy", busy, 0);
    chk("srst_in_ready", ifc.in_ready, 0);
    chk("srst_out_valid", ifc.out_valid, 0);
    chk("srst_out_sum", ifc.out_sum, 0);
    chk("srst_done", done, 0);
    @(posedge clk); #1;
    run_vec(tbl[0], "after_srst");

    // start pulses in ACC and READ are ignored.
    q.delete();
    for (int k = 0; k < 4; k++) q.push_back(rnd_grp());
    model_q();
    accepts = 0;
    start_ctb(2, 2);
    send_group(q[0], 0);
    send_group(q[1], 0);
    ctb_wg = 5'd1; ctb_h = 7'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_in_acc_busy", busy, 1);
    chk("start_in_acc_ready", ifc.in_ready, 1);
    send_group(q[2], 0);
    chk("start_in_acc_not_done_early", ifc.in_ready, 1);
    send_group(q[3], 0);
    chk("start_busy_accepts", accepts, 4);
    check_drain();
    read_results(50, 1'b1);
    cmp_results("start_busy");
    @(posedge clk); #1;
    chk("start_in_read_ignored", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
